// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - request/serial-output bundle of the pattern generator
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) ();
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] reps;
  logic             aout;
  logic             aout_valid;
  logic             sync;
  logic             busy;
  logic             done;

  // Requester side: issues bursts, observes the serial stream
  modport master (
    output start, pattern, pat_len, reps,
    input  aout, aout_valid, sync, busy, done
  );

  // Generator side
  modport slave (
    input  start, pattern, pat_len, reps,
    output aout, aout_valid, sync, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern burst source; SEQ_PATTERN_GEN_LFSR_FILL_EN selects LFSR gap filler
module seq_pattern_gen #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input logic             clk,
  input logic             reset,
  seq_pattern_gen_if.slave bus
);

  // Gap counter holds the number of gap cycles still to follow the current one
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GW-1:0]    GAP_LAST = (GAP_LEN > 0) ? GW'(GAP_LEN - 1) : '0;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic             aout_q, aout_n;
  logic             valid_q, valid_n;
  logic             sync_q, sync_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic [LEN_W-1:0] eff_len;
  logic             filler;

  // Selects bit i of a pattern without an over-wide index
  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // Requested length clamped to the pattern register width
  always_comb begin
    eff_len = (bus.pat_len > LEN_MAX) ? LEN_MAX : bus.pat_len;
  end

`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] lfsr_q, lfsr_n;

  // x^8+x^6+x^5+x^4+1, shifting toward bit 0; steps only at the end of a gap cycle
  always_comb begin
    lfsr_n = lfsr_q;
    if (state == GAP)
      lfsr_n = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
    filler = lfsr_n[0];
  end

  // LFSR register, seeded only by reset so noise continues across bursts
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_n;
  end
`else
  // Quiet filler between repetitions
  always_comb begin
    filler = 1'b0;
  end
`endif

  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    len_n   = len_q;
    idx_n   = idx_q;
    rep_n   = rep_q;
    gap_n   = gap_q;
    aout_n  = 1'b0;
    valid_n = 1'b0;
    sync_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pat_n = bus.pattern;
          len_n = eff_len;
          if (eff_len == '0 || bus.reps == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = SEND;
            rep_n   = bus.reps;
            idx_n   = eff_len - 1'b1;
            gap_n   = '0;
            aout_n  = bit_at(bus.pattern, eff_len - 1'b1);
            valid_n = 1'b1;
            sync_n  = 1'b1;
            busy_n  = 1'b1;
          end
        end
      end
      SEND: begin
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (idx_q != '0) begin
          idx_n  = idx_q - 1'b1;
          aout_n = bit_at(pat_q, idx_q - 1'b1);
        end else if (rep_q > CNT_W'(1)) begin
          rep_n = rep_q - 1'b1;
          if (GAP_LEN > 0) begin
            state_n = GAP;
            gap_n   = GAP_LAST;
            aout_n  = filler;
          end else begin
            idx_n  = len_q - 1'b1;
            aout_n = bit_at(pat_q, len_q - 1'b1);
            sync_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
          rep_n   = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (gap_q != '0) begin
          gap_n  = gap_q - 1'b1;
          aout_n = filler;
        end else begin
          state_n = SEND;
          idx_n   = len_q - 1'b1;
          aout_n  = bit_at(pat_q, len_q - 1'b1);
          sync_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and output registers; reset aborts any burst silently
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      aout_q  <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      idx_q   <= idx_n;
      rep_q   <= rep_n;
      gap_q   <= gap_n;
      aout_q  <= aout_n;
      valid_q <= valid_n;
      sync_q  <= sync_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.aout       = aout_q;
  assign bus.aout_valid = valid_q;
  assign bus.sync       = sync_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed checks of seq_pattern_gen burst timing and content
module tb_seq_pattern_gen;

  logic clk;
  logic reset;
  int   total;
  int   bad;

`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] tb_lfsr;
`endif

  seq_pattern_gen_if #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) sif ();

  seq_pattern_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP_LEN(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic a, input logic v, input logic s,
                     input logic b, input logic d);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {sif.aout, sif.aout_valid, sif.sync, sif.busy, sif.done};
    exp = {a, v, s, b, d};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (aout,valid,sync,busy,done)", tag, obs, exp);
    end
  endtask

  // Expected filler bit for the next gap cycle
  task automatic gap_bit(output logic g);
`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
    g = tb_lfsr[0];
    tb_lfsr = {tb_lfsr[0] ^ tb_lfsr[2] ^ tb_lfsr[3] ^ tb_lfsr[4], tb_lfsr[7:1]};
`else
    g = 1'b0;
`endif
  endtask

  task automatic model_reset();
`ifdef SEQ_PATTERN_GEN_LFSR_FILL_EN
    tb_lfsr = 8'hA5;
`endif
  endtask

  initial begin
    logic [3:0] pat4;
    logic [7:0] pat8;
    logic       g;
    int         pos;

    total = 0;
    bad   = 0;
    sif.start   = 1'b0;
    sif.pattern = '0;
    sif.pat_len = '0;
    sif.reps    = '0;
    reset = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk("reset", 0, 0, 0, 0, 0);

    // Single 3-bit repetition
    sif.pattern = 8'h07; sif.pat_len = 4'd3; sif.reps = 4'd1; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("t1_b0", 1, 1, 1, 1, 0);
    tick();
    chk("t1_b1", 1, 1, 0, 1, 0);
    tick();
    chk("t1_b2", 1, 1, 0, 1, 0);
    tick();
    chk("t1_done", 0, 0, 0, 0, 1);
    tick();
    chk("t1_idle", 0, 0, 0, 0, 0);

    // Three repetitions with gaps; a start during the burst must be ignored
    reset = 1'b1; model_reset(); tick(); reset = 1'b0;
    pat4 = 4'b1011;
    sif.pattern = 8'h0B; sif.pat_len = 4'd4; sif.reps = 4'd3; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pos = i % 6;
      if (pos < 4) chk($sformatf("t2_%0d", i), pat4[3 - pos], 1, pos == 0, 1, 0);
      else begin
        gap_bit(g);
        chk($sformatf("t2_gap_%0d", i), g, 1, 0, 1, 0);
      end
      if (i == 3) begin
        sif.start = 1'b1; sif.pattern = 8'hFF; sif.pat_len = 4'd8; sif.reps = 4'd1;
      end
      if (i == 5) sif.start = 1'b0;
      tick();
    end
    chk("t2_done", 0, 0, 0, 0, 1);
    tick();
    chk("t2_idle", 0, 0, 0, 0, 0);

    // Reset on the third bit aborts without a done pulse
    sif.pattern = 8'h0B; sif.pat_len = 4'd4; sif.reps = 4'd3; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("t4_b0", 1, 1, 1, 1, 0);
    tick();
    tick();
    chk("t4_b2", 1, 1, 0, 1, 0);
    reset = 1'b1; model_reset();
    tick();
    reset = 1'b0;
    chk("t4_abort", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_quiet_%0d", i), 0, 0, 0, 0, 0);
    end

    // Degenerate bursts: reps=0, then pat_len=0
    sif.pattern = 8'h0B; sif.pat_len = 4'd4; sif.reps = 4'd0; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("t3_reps0_done", 0, 0, 0, 0, 1);
    tick();
    chk("t3_reps0_idle", 0, 0, 0, 0, 0);
    sif.pat_len = 4'd0; sif.reps = 4'd3; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("t3_len0_done", 0, 0, 0, 0, 1);
    tick();
    chk("t3_len0_idle", 0, 0, 0, 0, 0);

    // Start held high: "10" bursts separated by one done cycle
    sif.pattern = 8'h02; sif.pat_len = 4'd2; sif.reps = 4'd1; sif.start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_%0d_b0", k), 1, 1, 1, 1, 0);
      tick();
      chk($sformatf("t5_%0d_b1", k), 0, 1, 0, 1, 0);
      tick();
      chk($sformatf("t5_%0d_done", k), 0, 0, 0, 0, 1);
      if (k == 2) sif.start = 1'b0;
      tick();
    end
    chk("t5_idle", 0, 0, 0, 0, 0);

    // pat_len beyond PAT_W sends exactly 8 bits
    pat8 = 8'hA5;
    sif.pattern = 8'hA5; sif.pat_len = 4'd12; sif.reps = 4'd1; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_clamp_%0d", i), pat8[7 - i], 1, i == 0, 1, 0);
      tick();
    end
    chk("t5_clamp_done", 0, 0, 0, 0, 1);

    // Maximum repetition count with a one-bit pattern: 15 + 14*2 valid cycles
    sif.pattern = 8'h01; sif.pat_len = 4'd1; sif.reps = 4'd15; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int i = 0; i < 43; i++) begin
      if (i % 3 == 0) chk($sformatf("t7_%0d", i), 1, 1, 1, 1, 0);
      else begin
        gap_bit(g);
        chk($sformatf("t7_gap_%0d", i), g, 1, 0, 1, 0);
      end
      tick();
    end
    chk("t7_done", 0, 0, 0, 0, 1);
    tick();
    chk("t7_idle", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
